// File: rtl/pipe_if_pcgen.sv
// pipe_if_pcgen -- fetch-stage PC generator.
// Owns the PC register and selects the next fetch address from pc_source
// (00 pc+INC, 01 conditional branch, 10 jump-register, 11 jump-immediate).
// Adds stall hold, interrupt entry, ERET return, EPC/IE state and an IF/ID
// fetch-valid flag.
// Optional feature macro: PIPE_IF_MISALIGN_EN. When defined, a redirect whose
// target has nonzero low two bits traps to EXC_VEC.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   stall                        hold all state this cycle
//   pc_source                    next-PC select
//   condit_bran_pc/j_reg_pc/j_pc redirect targets
//   int_req                      level interrupt request
//   eret                         return from handler
//   pc, epc, ie                  registered PC, saved restart PC, interrupt enable
//   pc4, next_pc                 combinational pc+INC and mux result
//   int_ack, exc_misalign        one-cycle pulses following a take
//   if_valid                     instruction at pc is valid for IF/ID
module pipe_if_pcgen #(
   parameter int                 ADDR_W    = 32,
   parameter int                 INC       = 4,
   parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
   parameter logic [ADDR_W-1:0]  INT_VEC   = ADDR_W'(32'h0000_0008),
   parameter logic [ADDR_W-1:0]  EXC_VEC   = ADDR_W'(32'h0000_000C)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic [1:0]        pc_source,
   input  logic [ADDR_W-1:0] condit_bran_pc,
   input  logic [ADDR_W-1:0] j_reg_pc,
   input  logic [ADDR_W-1:0] j_pc,
   input  logic              int_req,
   input  logic              eret,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc4,
   output logic [ADDR_W-1:0] next_pc,
   output logic [ADDR_W-1:0] epc,
   output logic              ie,
   output logic              int_ack,
   output logic              exc_misalign,
   output logic              if_valid
);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_BUBBLE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic              ie_q, ie_d;
   logic              int_ack_q, int_ack_d;
   logic              exc_q, exc_d;
   logic              misalign;

   // Next-PC mux; pc4 wraps naturally at ADDR_W bits.
   always_comb begin
      pc4 = pc_q + ADDR_W'(INC);
      case (pc_source)
         2'b01:   next_pc = condit_bran_pc;
         2'b10:   next_pc = j_reg_pc;
         2'b11:   next_pc = j_pc;
         default: next_pc = pc4;
      endcase
   end

`ifdef PIPE_IF_MISALIGN_EN
   // Sequential fall-through is always aligned; only redirects are checked.
   assign misalign = (pc_source != 2'b00) && (next_pc[1:0] != 2'b00);
`else
   // Targets are loaded unchecked; the exception branch below never fires.
   assign misalign = 1'b0;
`endif

   // Priority: stall > eret > exception > interrupt > normal.
   always_comb begin
      pc_d      = pc_q;
      epc_d     = epc_q;
      ie_d      = ie_q;
      int_ack_d = 1'b0;
      exc_d     = 1'b0;
      state_d   = state_q;
      if (!stall) begin
         state_d = S_RUN;
         if (eret) begin
            pc_d    = epc_q;
            ie_d    = 1'b1;
            state_d = S_BUBBLE;
         end else if (misalign) begin
            epc_d   = pc_q;        // restart at the faulting branch
            pc_d    = EXC_VEC;
            ie_d    = 1'b0;
            exc_d   = 1'b1;
            state_d = S_BUBBLE;
         end else if (ie_q && int_req) begin
            epc_d     = next_pc;   // resume where fetch would have gone
            pc_d      = INT_VEC;
            ie_d      = 1'b0;
            int_ack_d = 1'b1;
            state_d   = S_BUBBLE;
         end else begin
            pc_d = next_pc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_VEC;
         epc_q     <= '0;
         ie_q      <= 1'b0;
         int_ack_q <= 1'b0;
         exc_q     <= 1'b0;
         state_q   <= S_BOOT;
      end else begin
         pc_q      <= pc_d;
         epc_q     <= epc_d;
         ie_q      <= ie_d;
         int_ack_q <= int_ack_d;
         exc_q     <= exc_d;
         state_q   <= state_d;
      end
   end

   assign pc           = pc_q;
   assign epc          = epc_q;
   assign ie           = ie_q;
   assign int_ack      = int_ack_q;
   assign exc_misalign = exc_q;
   assign if_valid     = (state_q == S_RUN);

endmodule

// File: tb/tb_pipe_if_pcgen.sv
// Testbench for pipe_if_pcgen: directed scenarios followed by random cycles,
// all checked against a cycle-level behavioural model of the fetch PC rules.
module tb_pipe_if_pcgen;

   logic        clk = 1'b0;
   logic        rst, stall, int_req, eret;
   logic [1:0]  pc_source;
   logic [31:0] condit_bran_pc, j_reg_pc, j_pc;
   logic [31:0] pc, pc4, next_pc, epc;
   logic        ie, int_ack, exc_misalign, if_valid;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0] m_pc, m_epc;
   logic        m_ie, m_ack, m_exc, m_valid;

   pipe_if_pcgen dut (
      .clk(clk), .rst(rst), .stall(stall), .pc_source(pc_source),
      .condit_bran_pc(condit_bran_pc), .j_reg_pc(j_reg_pc), .j_pc(j_pc),
      .int_req(int_req), .eret(eret), .pc(pc), .pc4(pc4), .next_pc(next_pc),
      .epc(epc), .ie(ie), .int_ack(int_ack), .exc_misalign(exc_misalign),
      .if_valid(if_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_target(input logic [1:0] src);
      case (src)
         2'd0:    return m_pc + 32'd4;
         2'd1:    return condit_bran_pc;
         2'd2:    return j_reg_pc;
         default: return j_pc;
      endcase
   endfunction

   task automatic m_reset();
      m_pc = 32'h0; m_epc = 32'h0; m_ie = 1'b0;
      m_ack = 1'b0; m_exc = 1'b0; m_valid = 1'b0;
   endtask

   task automatic chk_all();
      chk("pc", pc, m_pc);
      chk("epc", epc, m_epc);
      chk("ie", {31'b0, ie}, {31'b0, m_ie});
      chk("int_ack", {31'b0, int_ack}, {31'b0, m_ack});
      chk("exc_misalign", {31'b0, exc_misalign}, {31'b0, m_exc});
      chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
      chk("pc4", pc4, m_pc + 32'd4);
      chk("next_pc", next_pc, m_target(pc_source));
   endtask

   // One clock: apply inputs at the negedge, check outputs, advance the model,
   // and return at the following negedge.
   task automatic drive(input logic r, input logic s, input logic [1:0] src,
                        input logic [31:0] cb, input logic [31:0] jr, input logic [31:0] j,
                        input logic irq, input logic er);
      logic [31:0] tgt;
      logic        bad;
      rst = r; stall = s; pc_source = src; condit_bran_pc = cb;
      j_reg_pc = jr; j_pc = j; int_req = irq; eret = er;
      #1;
      chk_all();
      tgt = m_target(src);
`ifdef PIPE_IF_MISALIGN_EN
      bad = (src != 2'd0) && (tgt % 4 != 0);
`else
      bad = 1'b0;
`endif
      if (r) m_reset();
      else if (s) begin
         m_ack = 1'b0; m_exc = 1'b0;
      end else begin
         m_ack = 1'b0; m_exc = 1'b0; m_valid = 1'b0;
         if (er) begin
            m_pc = m_epc; m_ie = 1'b1;
         end else if (bad) begin
            m_epc = m_pc; m_pc = 32'hC; m_ie = 1'b0; m_exc = 1'b1;
         end else if (m_ie && irq) begin
            m_epc = tgt; m_pc = 32'h8; m_ie = 1'b0; m_ack = 1'b1;
         end else begin
            m_pc = tgt; m_valid = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic seq(input logic [1:0] src, input logic [31:0] tgt, input logic irq);
      drive(1'b0, 1'b0, src, tgt, tgt, tgt, irq, 1'b0);
   endtask

   initial begin
      logic [31:0] t;
      logic        irq_mis;
      rst = 1'b1; stall = 1'b0; pc_source = 2'd0; condit_bran_pc = '0;
      j_reg_pc = '0; j_pc = '0; int_req = 1'b0; eret = 1'b0;
      m_reset();
      @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'b0, if_valid}, 32'h0);

      // Sequential fetch out of BOOT
      seq(2'd0, 0, 0); seq(2'd0, 0, 0); seq(2'd0, 0, 0);
      chk("seq_pc", pc, 32'hC);
      chk("seq_valid", {31'b0, if_valid}, 32'h1);
      seq(2'd0, 0, 0);
      seq(2'd3, 32'h100, 0);
      chk("jump_pc", pc, 32'h100);
      drive(1'b0, 1'b1, 2'd0, 0, 0, 0, 0, 0);
      drive(1'b0, 1'b1, 2'd0, 0, 0, 0, 0, 0);
      chk("stall_pc", pc, 32'h100);

      // eret from epc=0 enables interrupts, then take one at pc=0x20
      drive(1'b0, 1'b0, 2'd0, 0, 0, 0, 0, 1'b1);
      seq(2'd3, 32'h20, 0);
      seq(2'd0, 0, 1'b1);
      chk("int_pc", pc, 32'h8);
      chk("int_epc", epc, 32'h24);
      chk("int_ack", {31'b0, int_ack}, 32'h1);
      chk("int_valid", {31'b0, if_valid}, 32'h0);
      drive(1'b0, 1'b1, 2'd0, 0, 0, 0, 0, 1'b1);
      chk("eret_stall_pc", pc, 32'h8);
      drive(1'b0, 1'b0, 2'd0, 0, 0, 0, 0, 1'b1);
      chk("eret_pc", pc, 32'h24);
      chk("eret_ie", {31'b0, ie}, 32'h1);

      // Wrap at the top of the address space
      seq(2'd3, 32'hFFFF_FFFC, 0);
      chk("wrap_pc4", pc4, 32'h0);
      seq(2'd0, 0, 0);
      chk("wrap_pc", pc, 32'h0);

      // Misaligned jump-register target
      seq(2'd3, 32'h40, 0);
`ifdef PIPE_IF_MISALIGN_EN
      irq_mis = 1'b1;
`else
      irq_mis = 1'b0;
`endif
      drive(1'b0, 1'b0, 2'd2, 0, 32'h202, 0, irq_mis, 0);
`ifdef PIPE_IF_MISALIGN_EN
      chk("mis_pc", pc, 32'hC);
      chk("mis_epc", epc, 32'h40);
      chk("mis_exc", {31'b0, exc_misalign}, 32'h1);
      chk("mis_ack", {31'b0, int_ack}, 32'h0);
`else
      chk("mis_pc", pc, 32'h202);
      chk("mis_exc", {31'b0, exc_misalign}, 32'h0);
`endif

      // Random cycles
      for (int i = 0; i < 500; i++) begin
         t = $urandom;
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         drive($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
               2'($urandom_range(0, 3)), t, {t[31:2], 2'($urandom_range(0, 1) * 2)},
               $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2) == 0,
               $urandom_range(0, 9) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
